xyz_seq_driver: RTL and testbench
=================================

// Module: xyz_seq_driver
// PURPOSE
//  Upstream stimulus stage for the M3->M2->M1 interface hierarchy. Replaces the constant
//  drivers on u_I_z/u_I_y/u_I_x with a registered, parameterised pattern sequence.
//  Also checks the a/b/c loopback returned from the hierarchy, with a=z, b=y, c=x.
//  Counts mismatches and reports run completion through a start/done handshake.
// PARAMETERS
//  NUM_PAT      8                  number of {z,y,x} patterns per run (1..16)
//  PATTERNS     24'hFAC688         packed 3b patterns; pattern k = PATTERNS[3k+:3] = {z,y,x}
//  HOLD_CYCLES  2                  cycles each pattern is held (1..255)
//  LOOP_LAT     0                  a/b/c return latency in cycles (0..7); 0 = same-cycle compare
//  IDLE_PAT     3'b010             {z,y,x} driven in reset/idle (z=0,y=1,x=0)
// PORTS
//  i_clk        in   1   clock, rising edge
//  i_rst        in   1   synchronous reset, active-high
//  i_start      in   1   start a run; sampled only in IDLE
//  o_z          out  1   drives u_I_z
//  o_y          out  1   drives u_I_y
//  o_x          out  1   drives u_I_x
//  i_a          in   1   loopback of z from hierarchy
//  i_b          in   1   loopback of y
//  i_c          in   1   loopback of x
//  o_busy       out  1   high from the cycle after start until the DONE cycle (exclusive)
//  o_done       out  1   one-cycle pulse at end of run
//  o_pat_idx    out  4   index of pattern currently driven (0 when idle)
//  o_err_cnt    out  8   saturating mismatch count for the current/last run
// BEHAVIOUR
//  Reset values: {o_z,o_y,o_x}=IDLE_PAT, o_busy=0, o_done=0, o_pat_idx=0, o_err_cnt=0,
//   state=IDLE, delay line cleared (all valid bits 0).
//  FSM states: IDLE -> DRIVE -> DRAIN -> DONE -> IDLE. All outputs are registered.
//   IDLE: i_start=1 -> DRIVE; o_err_cnt<=0; pattern 0 visible on o_z/o_y/o_x next cycle.
//   DRIVE: hold pattern k for HOLD_CYCLES cycles, then advance k.
//    After k=NUM_PAT-1 completes: go to DRAIN if LOOP_LAT>0, else DONE.
//    On leaving DRIVE, outputs return to IDLE_PAT.
//   DRAIN: LOOP_LAT cycles so in-flight compares retire.
//   DONE: o_done=1 for exactly one cycle, o_busy=0, then IDLE. o_err_cnt holds until next start.
//  Run length: start at cycle 0; busy during cycles 1..NUM_PAT*HOLD_CYCLES+LOOP_LAT; done on the following cycle.
//  Check: every DRIVE cycle pushes {valid=1, expected=pattern} into the delay line.
//   The entry emerging after LOOP_LAT cycles is compared with {i_a,i_b,i_c}.
//   Any bit differing -> o_err_cnt += 1, saturating at 255 (no wrap).
//   Idle/drain cycles push valid=0, so no compare occurs outside a run.
//  i_start while busy, in DRAIN, or in DONE: ignored; no queueing, no restart.
//  i_rst mid-run: immediate return to reset values. No done pulse; pending compares are discarded.
//  o_pat_idx wraps to 0 only when the run ends; it never exceeds NUM_PAT-1.
//  Hold counter is 8b and the pattern index 4b; both are compared against param-1 (no overflow).
// STRUCTURE
//  Package xyz_pkg:
//   typedef struct packed {logic z,y,x;} xyz_t;
//   typedef enum logic [1:0] {IDLE,DRIVE,DRAIN,DONE} xyz_state_e;
//   localparam xyz_t XYZ_IDLE = 3'b010.
//  Sub-module xyz_delay_line: LOOP_LAT-deep shift register of {valid, xyz_t}.
//   Synchronous reset; pass-through when LOOP_LAT=0.
//  Top: FSM, hold/index counters, pattern mux, compare and saturating counter.
// TESTING
//  1. Reset then idle 5 cycles -> o_z=0,o_y=1,o_x=0; o_busy=0; o_err_cnt=0; no o_done.
//  2. Defaults, loopback wired a=z,b=y,c=x, start at cycle 0 -> busy cycles 1..16,
//     o_done at cycle 17, o_err_cnt=0, pattern k seen for 2 cycles each.
//  3. LOOP_LAT=3 with a 3-cycle delayed loopback -> busy cycles 1..19, done at 20, err=0.
//     Same bench with a 2-cycle delay -> err>0.
//  4. i_b tied 0, defaults -> err = 2 x (number of patterns with y=1).
//     Force i_b=0 for 300 cycles with HOLD_CYCLES=255 -> err saturates at 255.
//  5. i_start pulsed at cycles 0, 4 and 17 (DONE) -> exactly one run, single o_done,
//     err not cleared by the ignored starts.
//  6. i_rst asserted at cycle 7 of a run -> next cycle shows reset values;
//     no o_done; a fresh start then completes normally with err=0.

Source files
------------

// File: rtl/xyz_pkg.sv
// Shared types for the {z,y,x} sequence driver: pattern triple, FSM states,
// delay-line entry and the idle pattern.
package xyz_pkg;

    typedef struct packed {
        logic z;
        logic y;
        logic x;
    } xyz_t;

    typedef enum logic [1:0] {
        IDLE,
        DRIVE,
        DRAIN,
        DONE
    } xyz_state_e;

    typedef struct packed {
        logic valid;
        xyz_t xyz;
    } xyz_entry_t;

    localparam xyz_t XYZ_IDLE = 3'b010;

endpackage

// File: rtl/xyz_seq_driver_if.sv
// Stimulus/loopback bundle between the sequence driver and the M3->M2->M1 side.
interface xyz_seq_driver_if;

    logic       i_start;
    logic       o_z;
    logic       o_y;
    logic       o_x;
    logic       i_a;
    logic       i_b;
    logic       i_c;
    logic       o_busy;
    logic       o_done;
    logic [3:0] o_pat_idx;
    logic [7:0] o_err_cnt;

    modport master (
        input  i_start, i_a, i_b, i_c,
        output o_z, o_y, o_x, o_busy, o_done, o_pat_idx, o_err_cnt
    );

    modport slave (
        output i_start, i_a, i_b, i_c,
        input  o_z, o_y, o_x, o_busy, o_done, o_pat_idx, o_err_cnt
    );

endinterface

// File: rtl/xyz_delay_line.sv
// DEPTH-stage shift register of {valid, expected} entries aligning the driven
// pattern with its loopback; DEPTH=0 is a plain wire.
module xyz_delay_line
    import xyz_pkg::*;
#(
    parameter int unsigned DEPTH = 0
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  xyz_entry_t i_entry,
    output xyz_entry_t o_entry
);

    generate
        if (DEPTH == 0) begin : g_pass
            logic w_unused_clk_rst;
            assign w_unused_clk_rst = i_clk ^ i_rst;
            assign o_entry = i_entry;
        end else begin : g_sr
            xyz_entry_t r_sr [DEPTH];

            always_ff @(posedge i_clk) begin
                if (i_rst) begin
                    for (int unsigned k = 0; k < DEPTH; k++) begin
                        r_sr[k] <= '0;
                    end
                end else begin
                    r_sr[0] <= i_entry;
                    for (int unsigned k = 1; k < DEPTH; k++) begin
                        r_sr[k] <= r_sr[k-1];
                    end
                end
            end

            assign o_entry = r_sr[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/xyz_seq_driver.sv
// Registered {z,y,x} pattern sequencer with start/done handshake and a
// latency-aligned loopback checker counting mismatches (saturating at 255).
module xyz_seq_driver
    import xyz_pkg::*;
#(
    parameter int unsigned              NUM_PAT     = 8,
    parameter logic [3*NUM_PAT-1:0]     PATTERNS    = 24'hFAC688,
    parameter int unsigned              HOLD_CYCLES = 2,
    parameter int unsigned              LOOP_LAT    = 0,
    parameter xyz_t                     IDLE_PAT    = XYZ_IDLE
) (
    input  logic              i_clk,
    input  logic              i_rst,
    xyz_seq_driver_if.master  bus
);

    localparam logic [47:0] PAT_EXT    = 48'(PATTERNS);
    localparam logic [7:0]  HOLD_LAST  = 8'(HOLD_CYCLES - 1);
    localparam logic [3:0]  IDX_LAST   = 4'(NUM_PAT - 1);
    localparam logic [2:0]  DRAIN_LAST = 3'(LOOP_LAT - 1);

    xyz_state_e r_state;
    logic [7:0] r_hold;
    logic [3:0] r_idx;
    logic [2:0] r_drain;
    xyz_t       r_xyz;
    logic       r_busy;
    logic       r_done;
    logic [7:0] r_err;

    xyz_t       w_pat_tab [16];
    xyz_entry_t w_push;
    xyz_entry_t w_emerge;
    xyz_t       w_loop;
    logic       w_miss;

    // Full 16-entry table so the 4-bit index never leaves the array.
    always_comb begin
        for (int unsigned k = 0; k < 16; k++) begin
            w_pat_tab[k] = PAT_EXT[3*k +: 3];
        end
    end

    assign w_push = '{valid: (r_state == DRIVE), xyz: r_xyz};
    assign w_loop = '{z: bus.i_a, y: bus.i_b, x: bus.i_c};
    assign w_miss = w_emerge.valid && (w_emerge.xyz != w_loop);

    xyz_delay_line #(
        .DEPTH (LOOP_LAT)
    ) u_dly (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_entry (w_push),
        .o_entry (w_emerge)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= IDLE;
            r_hold  <= '0;
            r_idx   <= '0;
            r_drain <= '0;
            r_xyz   <= IDLE_PAT;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= '0;
        end else begin
            if (w_miss && (r_err != '1)) begin
                r_err <= r_err + 8'd1;
            end
            case (r_state)
                IDLE: begin
                    if (bus.i_start) begin
                        r_state <= DRIVE;
                        r_hold  <= '0;
                        r_idx   <= '0;
                        r_xyz   <= w_pat_tab[0];
                        r_busy  <= 1'b1;
                        r_err   <= '0;
                    end
                end
                DRIVE: begin
                    if (r_hold == HOLD_LAST) begin
                        r_hold <= '0;
                        if (r_idx == IDX_LAST) begin
                            r_idx <= '0;
                            r_xyz <= IDLE_PAT;
                            if (LOOP_LAT > 0) begin
                                r_state <= DRAIN;
                                r_drain <= '0;
                            end else begin
                                r_state <= DONE;
                                r_busy  <= 1'b0;
                                r_done  <= 1'b1;
                            end
                        end else begin
                            r_idx <= r_idx + 4'd1;
                            r_xyz <= w_pat_tab[r_idx + 4'd1];
                        end
                    end else begin
                        r_hold <= r_hold + 8'd1;
                    end
                end
                DRAIN: begin
                    if (r_drain == DRAIN_LAST) begin
                        r_state <= DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_drain <= r_drain + 3'd1;
                    end
                end
                DONE: begin
                    r_done  <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.o_z       = r_xyz.z;
    assign bus.o_y       = r_xyz.y;
    assign bus.o_x       = r_xyz.x;
    assign bus.o_busy    = r_busy;
    assign bus.o_done    = r_done;
    assign bus.o_pat_idx = r_idx;
    assign bus.o_err_cnt = r_err;

endmodule

// File: tb/tb_xyz_seq_driver.sv
// Directed/randomized bench for xyz_seq_driver: three parameterisations
// checked cycle by cycle against a behavioural run-timeline model.
module tb_xyz_seq_driver;

    localparam int          NUM    = 8;
    localparam logic [23:0] PATS   = 24'hFAC688;
    localparam int          HOLD_P [3] = '{2, 2, 255};
    localparam int          LAT_P  [3] = '{0, 3, 0};

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       st  [3];
    logic [2:0] lb  [3];

    logic [2:0] ozyx  [3];
    logic       obusy [3];
    logic       odone [3];
    logic [3:0] oidx  [3];
    logic [7:0] oerr  [3];

    int n_checks = 0;
    int n_errors = 0;
    int exp_err [3] = '{0, 0, 0};

    always #5 clk = ~clk;

    xyz_seq_driver_if if0 ();
    xyz_seq_driver_if if1 ();
    xyz_seq_driver_if if2 ();

    xyz_seq_driver u_dut0 (.i_clk(clk), .i_rst(rst), .bus(if0));
    xyz_seq_driver #(.LOOP_LAT(3)) u_dut1 (.i_clk(clk), .i_rst(rst), .bus(if1));
    xyz_seq_driver #(.HOLD_CYCLES(255)) u_dut2 (.i_clk(clk), .i_rst(rst), .bus(if2));

    assign if0.i_start = st[0];
    assign if1.i_start = st[1];
    assign if2.i_start = st[2];
    assign {if0.i_a, if0.i_b, if0.i_c} = lb[0];
    assign {if1.i_a, if1.i_b, if1.i_c} = lb[1];
    assign {if2.i_a, if2.i_b, if2.i_c} = lb[2];

    assign ozyx[0]  = {if0.o_z, if0.o_y, if0.o_x};
    assign ozyx[1]  = {if1.o_z, if1.o_y, if1.o_x};
    assign ozyx[2]  = {if2.o_z, if2.o_y, if2.o_x};
    assign obusy[0] = if0.o_busy;
    assign obusy[1] = if1.o_busy;
    assign obusy[2] = if2.o_busy;
    assign odone[0] = if0.o_done;
    assign odone[1] = if1.o_done;
    assign odone[2] = if2.o_done;
    assign oidx[0]  = if0.o_pat_idx;
    assign oidx[1]  = if1.o_pat_idx;
    assign oidx[2]  = if2.o_pat_idx;
    assign oerr[0]  = if0.o_err_cnt;
    assign oerr[1]  = if1.o_err_cnt;
    assign oerr[2]  = if2.o_err_cnt;

    // Pattern driven in cycle s of a run started in cycle 0.
    function automatic logic [2:0] model_out(input int sel, input int s);
        int          h = HOLD_P[sel];
        logic [23:0] p = PATS;
        if (s >= 1 && s <= NUM * h) return p[3*((s-1)/h) +: 3];
        return 3'b010;
    endfunction

    task automatic chk(input string tag, input int sel, input int t,
                       input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s dut%0d cyc%0d: observed=%0h expected=%0h", tag, sel, t, obs, exp);
        end
    endtask

    task automatic chk_all(input int sel, input int t, input logic [2:0] e_zyx,
                           input logic e_busy, input logic e_done,
                           input int e_idx, input int e_err);
        chk("zyx",  sel, t, 32'(ozyx[sel]),  32'(e_zyx));
        chk("busy", sel, t, 32'(obusy[sel]), 32'(e_busy));
        chk("done", sel, t, 32'(odone[sel]), 32'(e_done));
        chk("idx",  sel, t, 32'(oidx[sel]),  32'(e_idx));
        chk("err",  sel, t, 32'(oerr[sel]),  32'(e_err));
    endtask

    // One run on DUT 'sel': start in cycle 0, loopback delayed by 'dly'
    // cycles, random bit flips with probability flip_pct %, optional y
    // forced low, optional reset in cycle rst_cyc, optional extra starts.
    task automatic run(input int sel, input int dly, input int flip_pct,
                       input bit force_b0, input int rst_cyc, input bit multi_start);
        int         h      = HOLD_P[sel];
        int         l      = LAT_P[sel];
        int         nh     = NUM * h;
        int         t_done = nh + l + 1;
        int         t_end  = (rst_cyc >= 0) ? rst_cyc + 8 : t_done + 2;
        bit         aborted = 1'b0;
        logic [2:0] drv;
        for (int t = 0; t <= t_end; t++) begin
            @(posedge clk);
            #1;
            st[sel] = (t == 0) || (multi_start && (t == 4 || t == t_done));
            rst     = (t == rst_cyc);
            if (t - dly >= 1 && t - dly <= nh) drv = model_out(sel, t - dly);
            else                               drv = 3'($urandom);
            if (int'($urandom_range(99)) < flip_pct) drv = drv ^ 3'($urandom_range(7, 1));
            if (force_b0) drv[1] = 1'b0;
            lb[sel] = drv;
            @(negedge clk);
            if (rst_cyc >= 0 && t == rst_cyc + 1) begin
                aborted      = 1'b1;
                exp_err[sel] = 0;
            end
            if (aborted) begin
                chk_all(sel, t, 3'b010, 1'b0, 1'b0, 0, 0);
            end else if (t == 0) begin
                chk_all(sel, t, 3'b010, 1'b0, 1'b0, 0, exp_err[sel]);
                exp_err[sel] = 0;
            end else begin
                chk_all(sel, t, model_out(sel, t), (t <= nh + l), (t == t_done),
                        (t <= nh) ? (t - 1) / h : 0, exp_err[sel]);
                if (t - l >= 1 && t - l <= nh && drv != model_out(sel, t - l)
                    && exp_err[sel] < 255)
                    exp_err[sel]++;
            end
        end
        st[sel] = 1'b0;
        rst     = 1'b0;
    endtask

    initial begin
        for (int s = 0; s < 3; s++) begin
            st[s] = 1'b0;
            lb[s] = 3'b000;
        end
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state held through 5 idle cycles
        for (int t = 0; t < 5; t++) begin
            @(negedge clk);
            for (int s = 0; s < 3; s++) chk_all(s, t, 3'b010, 1'b0, 1'b0, 0, 0);
        end

        // Clean loopback, then random corruption, defaults
        run(0, 0, 0, 1'b0, -1, 1'b0);
        run(0, 0, 25, 1'b0, -1, 1'b0);

        // LOOP_LAT=3: matched 3-cycle loopback, then a mismatched 2-cycle one
        run(1, 3, 0, 1'b0, -1, 1'b0);
        run(1, 2, 0, 1'b0, -1, 1'b0);
        run(1, 3, 30, 1'b0, -1, 1'b0);

        // y stuck low, then saturation with 255-cycle holds
        run(0, 0, 0, 1'b1, -1, 1'b0);
        run(2, 0, 0, 1'b1, -1, 1'b0);

        // Starts during DRIVE and DONE are ignored, err kept afterwards
        run(0, 0, 20, 1'b0, -1, 1'b1);
        run(1, 3, 20, 1'b0, -1, 1'b1);

        // Reset in cycle 7 of a run, then a fresh clean run
        run(0, 0, 20, 1'b0, 7, 1'b0);
        run(0, 0, 0, 1'b0, -1, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
